agc_bit_select_48to16: RTL

Automatic bit-window selector that consumes the per-period 48-bit peak magnitude produced by the peak detector and reduces the 48-bit signed DDC data stream to 16-bit signed samples. At each measurement-period marker (`ms_in` rising edge) it captures the peak, finds its leading one, derives a right-shift with hysteresis, and applies it to the data path with rounding and saturation. It sits directly after the peak detector, on the same `ms_in` marker and the same data stream, feeding the 16-bit packetiser.

---
 rtl/agc_bit_select_48to16_if.sv | 26 ++
 rtl/agc_bit_select_48to16.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/agc_bit_select_48to16_if.sv
// Sample/marker bus between the AGC bit selector and its neighbours.
// The master modport drives marker, peak and data; the slave modport is the selector.
interface agc_bit_select_48to16_if #(
  parameter int DIN_W  = 48,
  parameter int DOUT_W = 16
);
  logic                     ms_in;
  logic [DIN_W-1:0]         peak_in;
  logic signed [DIN_W-1:0]  din;
  logic                     din_vld;
  logic signed [DOUT_W-1:0] dout;
  logic                     dout_vld;
  logic [5:0]               shift;
  logic                     shift_upd;
  logic                     sat_flag;

  modport master (
    output ms_in, peak_in, din, din_vld,
    input  dout, dout_vld, shift, shift_upd, sat_flag
  );

  modport slave (
    input  ms_in, peak_in, din, din_vld,
    output dout, dout_vld, shift, shift_upd, sat_flag
  );
endinterface

// File: rtl/agc_bit_select_48to16.sv
// Picks a 16-bit window of the 48-bit data stream from the per-period peak,
// with hysteresis on shift decreases, round-half-up and saturation.
module agc_bit_select_48to16 #(
  parameter int DIN_W      = 48,
  parameter int DOUT_W     = 16,
  parameter int HEADROOM   = 0,
  parameter int HYST       = 1,
  parameter int MAX_SHIFT  = 32,
  parameter int INIT_SHIFT = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  agc_bit_select_48to16_if.slave  bus
);
  localparam int HALF_W = DIN_W / 2;
  localparam int IDX_W  = $clog2(HALF_W);
  localparam int SH_W   = 6;
  localparam logic signed [DIN_W:0] SAT_HI = (DIN_W+1)'(2**(DOUT_W-1) - 1);
  localparam logic signed [DIN_W:0] SAT_LO = (DIN_W+1)'(-(2**(DOUT_W-1)));

  typedef enum logic [2:0] {WAIT_EDGE, WAIT_PEAK, ENC1, ENC2, APPLY} state_t;

  state_t                   state_q, state_d;
  logic                     d1_q, d2_q;
  logic                     wait_q, wait_d;
  logic [DIN_W-1:0]         peak_q, peak_d;
  logic [IDX_W-1:0]         lo_idx_q, lo_idx_d, hi_idx_q, hi_idx_d;
  logic                     lo_nz_q, lo_nz_d, hi_nz_q, hi_nz_d;
  logic [SH_W-1:0]          target_q, target_d;
  logic                     upd_q, upd_d;
  logic [SH_W-1:0]          shift_q, shift_d;
  logic                     shift_upd_q, shift_upd_d;
  logic signed [DIN_W:0]    v_q, v_d, ext, rnd;
  logic                     v_vld_q;
  logic signed [DOUT_W-1:0] dout_q, dout_d;
  logic                     dout_vld_q, sat_q, sat_d;
  int                       msb, tgt;

  function automatic logic [IDX_W-1:0] lead_one(input logic [HALF_W-1:0] x);
    lead_one = '0;
    for (int i = 0; i < HALF_W; i++)
      if (x[i]) lead_one = IDX_W'(i);
  endfunction

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    peak_d      = peak_q;
    lo_idx_d    = lo_idx_q;
    hi_idx_d    = hi_idx_q;
    lo_nz_d     = lo_nz_q;
    hi_nz_d     = hi_nz_q;
    target_d    = target_q;
    upd_d       = upd_q;
    shift_d     = shift_q;
    shift_upd_d = 1'b0;
    // A zero peak yields lo_idx = 0, so msb falls to 0 without a special case.
    msb = hi_nz_q ? HALF_W + int'(hi_idx_q) : int'(lo_idx_q);
    tgt = msb + 1 + HEADROOM - (DOUT_W - 1);
    if (tgt < 0) tgt = 0;
    if (tgt > MAX_SHIFT) tgt = MAX_SHIFT;
    case (state_q)
      WAIT_EDGE: if (d1_q && !d2_q) begin
        state_d = WAIT_PEAK;
        wait_d  = 1'b0;
      end
      WAIT_PEAK: if (wait_q) begin
        peak_d  = bus.peak_in;
        state_d = ENC1;
      end else begin
        wait_d = 1'b1;
      end
      ENC1: begin
        lo_idx_d = lead_one(peak_q[HALF_W-1:0]);
        hi_idx_d = lead_one(peak_q[DIN_W-1:HALF_W]);
        lo_nz_d  = |peak_q[HALF_W-1:0];
        hi_nz_d  = |peak_q[DIN_W-1:HALF_W];
        state_d  = ENC2;
      end
      ENC2: begin
        target_d = SH_W'(tgt);
        upd_d    = (tgt > int'(shift_q)) || ((int'(shift_q) - tgt) > HYST);
        state_d  = APPLY;
      end
      APPLY: begin
        if (upd_q) begin
          shift_d     = target_q;
          shift_upd_d = 1'b1;
        end
        state_d = WAIT_EDGE;
      end
      default: state_d = WAIT_EDGE;
    endcase
  end

  // Stage 1 reads shift_q in the same cycle it samples din, so each sample sees one shift.
  always_comb begin
    ext = {bus.din[DIN_W-1], bus.din};
    rnd = '0;
    if (shift_q != '0) rnd[shift_q - 1'b1] = 1'b1;
    v_d = v_q;
    if (bus.din_vld) v_d = (ext + rnd) >>> shift_q;
    dout_d = dout_q;
    sat_d  = 1'b0;
    if (v_vld_q) begin
      if (v_q > SAT_HI) begin
        dout_d = {1'b0, {(DOUT_W-1){1'b1}}};
        sat_d  = 1'b1;
      end else if (v_q < SAT_LO) begin
        dout_d = {1'b1, {(DOUT_W-1){1'b0}}};
        sat_d  = 1'b1;
      end else begin
        dout_d = v_q[DOUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_EDGE;
      d1_q        <= 1'b0;
      d2_q        <= 1'b0;
      wait_q      <= 1'b0;
      peak_q      <= '0;
      lo_idx_q    <= '0;
      hi_idx_q    <= '0;
      lo_nz_q     <= 1'b0;
      hi_nz_q     <= 1'b0;
      target_q    <= '0;
      upd_q       <= 1'b0;
      shift_q     <= SH_W'(INIT_SHIFT);
      shift_upd_q <= 1'b0;
      v_q         <= '0;
      v_vld_q     <= 1'b0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      d1_q        <= bus.ms_in;
      d2_q        <= d1_q;
      wait_q      <= wait_d;
      peak_q      <= peak_d;
      lo_idx_q    <= lo_idx_d;
      hi_idx_q    <= hi_idx_d;
      lo_nz_q     <= lo_nz_d;
      hi_nz_q     <= hi_nz_d;
      target_q    <= target_d;
      upd_q       <= upd_d;
      shift_q     <= shift_d;
      shift_upd_q <= shift_upd_d;
      v_q         <= v_d;
      v_vld_q     <= bus.din_vld;
      dout_q      <= dout_d;
      dout_vld_q  <= v_vld_q;
      sat_q       <= sat_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = dout_vld_q;
  assign bus.shift     = shift_q;
  assign bus.shift_upd = shift_upd_q;
  assign bus.sat_flag  = sat_q;
endmodule
